// File: rtl/timer_ctrl.sv
// timer_ctrl: run/direction/unit sequencer for the stopwatch/timer counter bank.
// Debounces the pause button, decodes joystick X into start/direction commands,
// steps display units on a sustained joystick Y hold, and drives the expiry alarm.
// Optional feature macro: TIMER_CTRL_ALARM_EN (defined builds the ALARM state,
// alarm_cnt and sound drive; undefined sends countdown expiry to PAUSED and ties
// sound_out low).
module timer_ctrl #(
  parameter int unsigned JSTK_HI     = 800,
  parameter int unsigned JSTK_LO     = 200,
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned DEB_MS      = 20,
  parameter int unsigned ALARM_MS    = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1ms,
  input  logic       pause_btn,
  input  logic [9:0] jstk_x,
  input  logic [9:0] jstk_y,
  input  logic       digits_zero,
  input  logic       clk_sound,
  output logic       run,
  output logic       dir_fwd,
  output logic [1:0] units,
  output logic       units_chg,
  output logic       sound_out,
  output logic [1:0] state
);

  localparam int unsigned JW     = 10;
  localparam int unsigned DEB_W  = $clog2(DEB_MS + 1);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_ALARM  = 2'd3
  } state_t;

  state_t state_q, state_n;
  logic   dir_q, dir_n;
  logic   run_q;

  logic [1:0]       sync_q;
  logic             deb_level;
  logic             deb_prev;
  logic [DEB_W-1:0] deb_cnt;
  logic             pev;

  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        units_q;
  logic              units_chg_q;
  logic              y_dec, y_inc;

  logic x_hi, x_lo, xcmd;

  // Pause path: 2-flop synchronizer, tick-based debounce, rising-edge event
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b00;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync_q   <= {sync_q[0], pause_btn};
      deb_prev <= deb_level;
      if (sync_q[1] == deb_level) begin
        deb_cnt <= '0;
      end else if (tick_1ms) begin
        if (deb_cnt == DEB_W'(DEB_MS - 1)) begin
          deb_level <= sync_q[1];
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end
  end

  assign pev = deb_level & ~deb_prev;

  // X command: deflection high starts counting down, low starts counting up
  assign x_hi = (jstk_x >= JW'(JSTK_HI));
  assign x_lo = (jstk_x <= JW'(JSTK_LO));
  assign xcmd = x_hi | x_lo;

  // Y stepping qualifiers: a direction already at its limit never accumulates
  assign y_dec = (jstk_y >= JW'(JSTK_HI)) && (units_q != 2'd0);
  assign y_inc = (jstk_y <= JW'(JSTK_LO)) && (units_q != 2'd2);

`ifdef TIMER_CTRL_ALARM_EN
  localparam int unsigned ALM_W = $clog2(ALARM_MS + 1);

  logic [ALM_W-1:0] alarm_cnt;
  logic             alarm_done;
  logic             sound_q;

  assign alarm_done = tick_1ms && (alarm_cnt == ALM_W'(ALARM_MS - 1));

  // Alarm duration counter, held at zero outside ALARM so entry starts fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_cnt <= '0;
    end else if (state_q != ST_ALARM) begin
      alarm_cnt <= '0;
    end else if (tick_1ms) begin
      alarm_cnt <= alarm_cnt + 1'b1;
    end
  end

  // Speaker drive gated by the upcoming state so it drops with the ALARM exit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sound_q <= 1'b0;
    end else begin
      sound_q <= (state_n == ST_ALARM) & clk_sound;
    end
  end

  assign sound_out = sound_q;
`else
  wire unused_sound = &{1'b0, clk_sound};

  assign sound_out = 1'b0;
`endif

  // State, direction and run registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      run_q   <= (state_n == ST_RUN);
    end
  end

  // Next-state and direction decode; pause event outranks joystick X
  always_comb begin
    state_n = state_q;
    dir_n   = dir_q;
    case (state_q)
      ST_IDLE, ST_PAUSED: begin
        if (pev) begin
          state_n = ST_RUN;
        end else if (xcmd) begin
          state_n = ST_RUN;
          dir_n   = x_lo;
        end
      end
      ST_RUN: begin
        if (pev) begin
          state_n = ST_PAUSED;
        end else if (!dir_q && digits_zero) begin
`ifdef TIMER_CTRL_ALARM_EN
          state_n = ST_ALARM;
`else
          state_n = ST_PAUSED;
`endif
        end else if (xcmd) begin
          dir_n = x_lo;
        end
      end
      ST_ALARM: begin
`ifdef TIMER_CTRL_ALARM_EN
        if (pev || alarm_done) begin
          state_n = ST_IDLE;
        end
`else
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Unit stepping on a sustained Y deflection, repeating every HOLD_CYCLES
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt    <= '0;
      units_q     <= 2'd1;
      units_chg_q <= 1'b0;
    end else begin
      units_chg_q <= 1'b0;
      if (!(y_dec || y_inc)) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
        hold_cnt    <= '0;
        units_chg_q <= 1'b1;
        if (y_dec) begin
          units_q <= units_q - 2'd1;
        end else begin
          units_q <= units_q + 2'd1;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign state     = state_q;
  assign run       = run_q;
  assign dir_fwd   = dir_q;
  assign units     = units_q;
  assign units_chg = units_chg_q;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Control sequencer for the stopwatch/timer counter datapath. Turns raw user inputs (pause button, joystick X/Y) into clean run, direction and display-unit commands. Detects countdown expiry from the datapath and drives a timed, gated alarm tone. Sits between the input front-end (button pin, joystick SPI decoder) and the counter bank. Its outputs replace the ad-hoc run/direction/unit logic formerly embedded in the counter.

## Interface
- JSTK_HI, 800: joystick deflection threshold; value >= JSTK_HI counts as high.
- JSTK_LO, 200: joystick deflection threshold; value <= JSTK_LO counts as low.
- HOLD_CYCLES, 25_000_000: consecutive clk cycles of Y deflection needed per unit step.
- DEB_MS, 20: ms the synchronized pause input must be stable to be accepted.
- ALARM_MS, 3000: alarm duration in ms.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- tick_1ms  in  1  one-cycle strobe every 1 ms, synchronous to clk.
- pause_btn  in  1  raw, asynchronous pause pushbutton, active-high.
- jstk_x  in  10  joystick X position, synchronous to clk.
- jstk_y  in  10  joystick Y position, synchronous to clk.
- digits_zero  in  1  datapath reports all four displayed digits are 0.
- clk_sound  in  1  audio square wave, synchronous to clk.
- run  out  1  counter enable.
- dir_fwd  out  1  1 = count up, 0 = count down.
- units  out  2  0 = milliseconds, 1 = min/sec, 2 = hr/min; 3 is never driven.
- units_chg  out  1  one-cycle pulse when units changes.
- sound_out  out  1  speaker drive.
- state  out  2  0 IDLE, 1 RUN, 2 PAUSED, 3 ALARM.

## Operation
- Reset values: state=IDLE, run=0, dir_fwd=1, units=1, units_chg=0, sound_out=0. All counters and synchronizer flops reset to 0.
- Pause path:
  - pause_btn passes through a 2-flop synchronizer.
  - The debounced level updates only after the synchronized value differs from it and stays constant for DEB_MS consecutive tick_1ms strobes. Any change restarts the count.
  - A rising edge of the debounced level produces a one-cycle pause event (pev).
- X command (xcmd): jstk_x>=JSTK_HI means start down (dir_fwd=0). jstk_x<=JSTK_LO means start up (dir_fwd=1). The command is level-sensitive.
- FSM, evaluated in priority order each cycle:
  - IDLE: pev goes to RUN. xcmd goes to RUN and loads dir_fwd.
  - RUN: pev goes to PAUSED. Else if dir_fwd=0 and digits_zero=1, go to ALARM. Else xcmd loads dir_fwd and stays in RUN.
  - PAUSED: pev goes to RUN. xcmd goes to RUN and loads dir_fwd.
  - ALARM: pev goes to IDLE. Else, when alarm_cnt reaches ALARM_MS tick_1ms strobes, go to IDLE. xcmd is ignored.
  - pev wins over xcmd in the same cycle.
- run=1 only in RUN, and is registered from the next state.
- Y unit stepping:
  - hold_cnt ($clog2(HOLD_CYCLES) bits) increments each cycle jstk_y>=JSTK_HI (units>0) or jstk_y<=JSTK_LO (units<2).
  - It clears when Y is neutral, or when the direction is blocked at its limit.
  - When hold_cnt==HOLD_CYCLES-1 and still deflected, units steps (high decrements, low increments). On that same edge hold_cnt clears and units_chg pulses.
  - A continuous hold steps again after every further HOLD_CYCLES cycles.
  - Unit stepping is allowed in every state.
- sound_out = clk_sound registered while in ALARM, 0 otherwise.

## Timing
- All outputs are registered. state, run and dir_fwd update on the edge after the triggering input is sampled.
- Pause latency: press to debounced edge takes 2 cycles plus DEB_MS strobes. run toggles 1 cycle after pev.
- Expiry: digits_zero sampled high in RUN (counting down) gives state=ALARM and run=0 on the next edge. sound_out follows clk_sound with a 1-cycle delay.
- alarm_cnt clears on ALARM entry and counts tick_1ms strobes. On the strobe that makes the count equal ALARM_MS, the next state is IDLE and sound_out=0 on the following edge.
- Reset asserted mid-operation forces reset values immediately (asynchronously), including in ALARM with sound active.
- digits_zero is ignored when dir_fwd=1 or state≠RUN.

## Configuration
- TIMER_CTRL_ALARM_EN defined: ALARM state, alarm_cnt and sound_out behave as specified above.
- TIMER_CTRL_ALARM_EN undefined:
  - Countdown expiry (RUN, dir_fwd=0, digits_zero=1) goes to PAUSED.
  - ALARM is unreachable; sound_out is tied to 0; alarm_cnt is not built.
  - Ports are unchanged.

## Test plan
Test parameters: HOLD_CYCLES=8, DEB_MS=2, ALARM_MS=4. tick_1ms pulses every 10 cycles. Alarm macro defined unless stated.
- Reset release with neutral inputs -> state=0, run=0, dir_fwd=1, units=1, sound_out=0 for 50 cycles.
- pause_btn high with a 1-cycle glitch, then held high -> exactly one pev after 2 stable strobes. IDLE goes to RUN (run=1), then a second clean press gives PAUSED (run=0).
- jstk_y=900 for 20 cycles from units=1 -> units=0 on cycle 8 with one units_chg pulse. No further change because the limit is reached. Then jstk_y=100 for 16 cycles -> units=1 at cycle 8, units=2 at cycle 16.
- jstk_x=900 (RUN, down), then digits_zero=1 -> state=3 and run=0 next edge. sound_out tracks clk_sound for 4 strobes, then state=0 and sound_out=0.
- In ALARM, pev and jstk_x=100 in the same cycle -> state=IDLE, dir_fwd unchanged, sound_out=0.
- Macro undefined, same expiry stimulus as above -> state=2, run=0, sound_out stays 0.
